memory_checker: RTL and testbench
=================================

// Module: memory_checker
// PURPOSE
//  Parametrised memory-mapped result checker for CPU test benches. Sits on the CPU data bus next to the
//  test ROM, latches every write into a window of array_size words and compares each word against an
//  expected image. Reports pass/fail, error count and first failing index; readback is OR-able onto dIn.
//  Adds sticky-fail mode, error statistics, readback and sync clear.
// PARAMETERS
//  base_addr      8'h80       first bus address of the checked window
//  addr_size      8           bus address width
//  word_size      8           bus data width
//  array_size     3           number of checked words (>=1)
//  array_content  24'h64_0700 expected image, word i = array_content[(array_size-1-i)*word_size +: word_size]
//  sticky_fail    0           0: content_ok reflects current stored words; 1: any mismatching write latches fail
//  cnt_width      8           width of err_count (saturating)
// PORTS
//  clk            in   1               bench clock, all state on rising edge
//  reset          in   1               asynchronous, active-high
//  clear          in   1               synchronous clear of all check state
//  addr           in   addr_size       CPU address
//  data_in        in   word_size       CPU write data
//  write_en       in   1               CPU write strobe
//  data_out       out  word_size       readback, zero when window not addressed
//  content_ok     out  1               all words written and matching (and no latched fail if sticky_fail)
//  fail           out  1               at least one mismatching write since reset/clear
//  err_count      out  cnt_width       number of mismatching writes, saturates at all-ones
//  first_err_idx  out  clog2(array_size) (min 1)  index of first mismatching write
// BEHAVIOUR
//  - hit = addr >= base_addr && addr < base_addr+array_size, compared in addr_size+1 bits (no wrap);
//    idx = addr - base_addr. Elaboration error if base_addr+array_size > 2**addr_size.
//  - Reset (async) and clear (sync, priority over write): stored words=0, written bitmap=0, fail=0,
//    err_count=0, first_err_idx=0, data_out=0; hence content_ok=0.
//  - Write (write_en && hit): mem[idx]<=data_in, written[idx]<=1. If data_in != expected[idx]: err_count
//    +1 unless all-ones; if fail==0 then first_err_idx<=idx; fail<=1. Rewrites of same index are legal.
//  - Writes outside window ignored entirely (no count, no state change).
//  - content_ok combinational from registers: &written && (mem==expected for every i) && !(sticky_fail && fail).
//    So it rises in the cycle after the edge that captures the last correct word.
//  - sticky_fail=0: a later correcting write restores content_ok; fail/err_count remain as history.
//  - Readback: data_out registered, 1-cycle latency. Edge with hit && !write_en: data_out<=mem[idx].
//    Any other edge (miss, or write cycle): data_out<=0. Unwritten words read as 0.
//  - first_err_idx only meaningful while fail==1.
//  - No handshake/back-pressure: every bus cycle is accepted.
// TESTING
//  1 defaults; write 0x80=64,0x81=07,0x82=00 -> content_ok=1 one cycle after third edge, fail=0, err_count=0
//  2 write 0x81=08 then 0x81=07 (others correct), sticky_fail=0 -> fail=1, err_count=1, first_err_idx=1,
//    content_ok=1 after correction; same with sticky_fail=1 -> content_ok stays 0
//  3 write 0x7F and 0x83 with any data -> no state change, err_count=0, content_ok=0
//  4 write 0x80=AA, then read 0x80 -> data_out=AA on following cycle; read 0x10 -> data_out=00
//  5 cnt_width=2, four mismatching writes to 0x82 -> err_count=3 (saturated), first_err_idx=2
//  6 reset asserted mid-sequence after two correct writes -> content_ok=0, data_out=0 immediately (async);
//    clear together with write to 0x80 -> write discarded, all state 0

Source files
------------

// File: rtl/memory_checker.sv
`default_nettype none
// ============================================================================
// memory_checker : snoops CPU bus writes into a small address window and
//                  compares the captured words against an expected image
// Revision 1.0
// ============================================================================
module memory_checker #(
   parameter int unsigned                       base_addr     = 8'h80,
   parameter int unsigned                       addr_size     = 8,
   parameter int unsigned                       word_size     = 8,
   parameter int unsigned                       array_size    = 3,
   parameter logic [array_size*word_size-1:0]   array_content = 24'h64_0700,
   parameter bit                                sticky_fail   = 1'b0,
   parameter int unsigned                       cnt_width     = 8,
   localparam int unsigned                      IDX_W         = (array_size > 1) ? $clog2(array_size) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic [addr_size-1:0]   addr,
   input  logic [word_size-1:0]   data_in,
   input  logic                   write_en,
   output logic [word_size-1:0]   data_out,
   output logic                   content_ok,
   output logic                   fail,
   output logic [cnt_width-1:0]   err_count,
   output logic [IDX_W-1:0]       first_err_idx
);

   // Image word 0 lives in the most significant slice of array_content.
   function automatic logic [array_size-1:0][word_size-1:0] unpack_image(
      input logic [array_size*word_size-1:0] img
   );
      logic [array_size-1:0][word_size-1:0] r;
      for (int i = 0; i < int'(array_size); i++) begin
         r[i] = img[(int'(array_size) - 1 - i)*int'(word_size) +: word_size];
      end
      return r;
   endfunction

   localparam logic [array_size-1:0][word_size-1:0] C_EXPECTED = unpack_image(array_content);
   localparam logic [addr_size:0] C_BASE  = (addr_size+1)'(base_addr);
   localparam logic [addr_size:0] C_LIMIT = (addr_size+1)'(base_addr + array_size);

   generate
      if ((longint'(base_addr) + longint'(array_size)) > (longint'(1) << addr_size)) begin : g_range_check
         $error("memory_checker: window base_addr+array_size exceeds the address space");
      end
   endgenerate

   logic [addr_size:0]                    addr_ext;
   logic                                  hit;
   logic [IDX_W-1:0]                      idx;
   logic                                  mismatch;
   logic                                  all_match;

   logic [array_size-1:0][word_size-1:0]  mem_q, mem_d;
   logic [array_size-1:0]                 written_q, written_d;
   logic                                  fail_q, fail_d;
   logic [cnt_width-1:0]                  err_count_q, err_count_d;
   logic [IDX_W-1:0]                      first_err_idx_q, first_err_idx_d;
   logic [word_size-1:0]                  data_out_q, data_out_d;

   // Compare one bit wider than the bus so the window end never wraps.
   always_comb begin
      addr_ext = {1'b0, addr};
      hit      = (addr_ext >= C_BASE) && (addr_ext < C_LIMIT);
      idx      = IDX_W'(addr_ext - C_BASE);
   end

   always_comb begin
      mem_d           = mem_q;
      written_d       = written_q;
      fail_d          = fail_q;
      err_count_d     = err_count_q;
      first_err_idx_d = first_err_idx_q;
      data_out_d      = '0;
      mismatch        = 1'b0;

      if (clear) begin
         mem_d           = '0;
         written_d       = '0;
         fail_d          = 1'b0;
         err_count_d     = '0;
         first_err_idx_d = '0;
      end else if (hit && write_en) begin
         for (int i = 0; i < int'(array_size); i++) begin
            if (idx == IDX_W'(i)) begin
               mem_d[i]     = data_in;
               written_d[i] = 1'b1;
               mismatch     = (data_in != C_EXPECTED[i]);
            end
         end
         if (mismatch) begin
            if (err_count_q != '1) begin
               err_count_d = err_count_q + cnt_width'(1);
            end
            if (!fail_q) begin
               first_err_idx_d = idx;
            end
            fail_d = 1'b1;
         end
      end else if (hit) begin
         for (int i = 0; i < int'(array_size); i++) begin
            if (idx == IDX_W'(i)) begin
               data_out_d = mem_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q           <= '0;
         written_q       <= '0;
         fail_q          <= 1'b0;
         err_count_q     <= '0;
         first_err_idx_q <= '0;
         data_out_q      <= '0;
      end else begin
         mem_q           <= mem_d;
         written_q       <= written_d;
         fail_q          <= fail_d;
         err_count_q     <= err_count_d;
         first_err_idx_q <= first_err_idx_d;
         data_out_q      <= data_out_d;
      end
   end

   // Sticky mode keeps content_ok low once any bad write has been seen.
   always_comb begin
      all_match  = (mem_q == C_EXPECTED);
      content_ok = (&written_q) && all_match && !(sticky_fail && fail_q);
   end

   assign data_out      = data_out_q;
   assign fail          = fail_q;
   assign err_count     = err_count_q;
   assign first_err_idx = first_err_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_checker.sv
`default_nettype none
// Testbench for memory_checker: default, sticky-fail and narrow-counter instances
// share one bus; readback is checked through a scoreboard queue.
module tb_memory_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic [7:0] addr;
   logic [7:0] data_in;
   logic       write_en;

   logic [7:0] dout_a,  dout_s,  dout_c;
   logic       ok_a,    ok_s,    ok_c;
   logic       fail_a,  fail_s,  fail_c;
   logic [7:0] cnt_a,   cnt_s;
   logic [1:0] cnt_c;
   logic [1:0] fidx_a,  fidx_s,  fidx_c;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb_q[$];
   logic [7:0] m_mem[3];

   always #5 clk = ~clk;

   memory_checker dut (
      .clk(clk), .reset(reset), .clear(clear), .addr(addr), .data_in(data_in),
      .write_en(write_en), .data_out(dout_a), .content_ok(ok_a), .fail(fail_a),
      .err_count(cnt_a), .first_err_idx(fidx_a)
   );

   memory_checker #(.sticky_fail(1'b1)) dut_sticky (
      .clk(clk), .reset(reset), .clear(clear), .addr(addr), .data_in(data_in),
      .write_en(write_en), .data_out(dout_s), .content_ok(ok_s), .fail(fail_s),
      .err_count(cnt_s), .first_err_idx(fidx_s)
   );

   memory_checker #(.cnt_width(2)) dut_cnt2 (
      .clk(clk), .reset(reset), .clear(clear), .addr(addr), .data_in(data_in),
      .write_en(write_en), .data_out(dout_c), .content_ok(ok_c), .fail(fail_c),
      .err_count(cnt_c), .first_err_idx(fidx_c)
   );

   // One bus cycle; the expected readback is queued before the edge and checked after it.
   task automatic cycle(input logic [7:0] a, input logic [7:0] d, input logic we, input logic clr);
      logic [7:0] exp_do;
      logic [7:0] got;
      bit         h;
      int         i;
      addr = a; data_in = d; write_en = we; clear = clr;
      h = (a >= 8'h80) && (a < 8'h83);
      i = int'(a) - 8'h80;
      exp_do = 8'h00;
      if (clr) begin
         for (int k = 0; k < 3; k++) m_mem[k] = 8'h00;
      end else if (we && h) begin
         m_mem[i] = d;
      end else if (h) begin
         exp_do = m_mem[i];
      end
      sb_q.push_back(exp_do);
      @(posedge clk);
      @(negedge clk);
      got = sb_q.pop_front();
      checks++;
      if (dout_a !== got) begin
         errors++;
         $display("FAIL readback addr=%h: data_out=%h expected=%h", a, dout_a, got);
      end
      write_en = 1'b0; clear = 1'b0; addr = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1; clear = 1'b0; write_en = 1'b0; addr = 8'h00; data_in = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) m_mem[k] = 8'h00;
      sb_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ok_a, fail_a, cnt_a, fidx_a, dout_a} !== 19'h0) begin
         errors++;
         $display("FAIL reset_state: ok=%b fail=%b cnt=%h idx=%h dout=%h expected all 0",
                  ok_a, fail_a, cnt_a, fidx_a, dout_a);
      end
   endtask

   task automatic test_correct_image();
      do_reset();
      cycle(8'h80, 8'h64, 1'b1, 1'b0);
      cycle(8'h81, 8'h07, 1'b1, 1'b0);
      checks++;
      if (ok_a !== 1'b0) begin errors++; $display("FAIL ok_partial: got %b expected 0", ok_a); end
      cycle(8'h82, 8'h00, 1'b1, 1'b0);
      checks++;
      if (ok_a !== 1'b1) begin errors++; $display("FAIL ok_full: got %b expected 1", ok_a); end
      checks++;
      if (fail_a !== 1'b0 || cnt_a !== 8'd0) begin
         errors++; $display("FAIL clean_stats: fail=%b cnt=%0d expected 0/0", fail_a, cnt_a);
      end
   endtask

   task automatic test_mismatch_correction();
      do_reset();
      cycle(8'h80, 8'h64, 1'b1, 1'b0);
      cycle(8'h81, 8'h08, 1'b1, 1'b0);
      cycle(8'h82, 8'h00, 1'b1, 1'b0);
      checks++;
      if (fail_a !== 1'b1 || cnt_a !== 8'd1 || fidx_a !== 2'd1 || ok_a !== 1'b0) begin
         errors++;
         $display("FAIL mismatch_stats: fail=%b cnt=%0d idx=%0d ok=%b expected 1/1/1/0",
                  fail_a, cnt_a, fidx_a, ok_a);
      end
      cycle(8'h81, 8'h07, 1'b1, 1'b0);
      checks++;
      if (ok_a !== 1'b1) begin errors++; $display("FAIL ok_restored: got %b expected 1", ok_a); end
      checks++;
      if (fail_a !== 1'b1 || cnt_a !== 8'd1) begin
         errors++; $display("FAIL history_kept: fail=%b cnt=%0d expected 1/1", fail_a, cnt_a);
      end
      checks++;
      if (ok_s !== 1'b0 || fail_s !== 1'b1 || fidx_s !== 2'd1) begin
         errors++;
         $display("FAIL sticky_ok: ok=%b fail=%b idx=%0d expected 0/1/1", ok_s, fail_s, fidx_s);
      end
   endtask

   task automatic test_out_of_window();
      do_reset();
      cycle(8'h7F, 8'h64, 1'b1, 1'b0);
      cycle(8'h83, 8'hAA, 1'b1, 1'b0);
      checks++;
      if (cnt_a !== 8'd0 || fail_a !== 1'b0 || ok_a !== 1'b0) begin
         errors++;
         $display("FAIL outside_write: cnt=%0d fail=%b ok=%b expected 0/0/0", cnt_a, fail_a, ok_a);
      end
      cycle(8'h7F, 8'h00, 1'b0, 1'b0);
      cycle(8'h80, 8'h00, 1'b0, 1'b0);
      cycle(8'h82, 8'h00, 1'b0, 1'b0);
      cycle(8'h83, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_readback();
      do_reset();
      cycle(8'h80, 8'hAA, 1'b1, 1'b0);
      cycle(8'h80, 8'h00, 1'b0, 1'b0);
      cycle(8'h10, 8'h00, 1'b0, 1'b0);
      cycle(8'h81, 8'h00, 1'b0, 1'b0);
      checks++;
      if (fail_a !== 1'b1 || cnt_a !== 8'd1 || fidx_a !== 2'd0) begin
         errors++;
         $display("FAIL readback_stats: fail=%b cnt=%0d idx=%0d expected 1/1/0", fail_a, cnt_a, fidx_a);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int n = 0; n < 4; n++) cycle(8'h82, 8'h11 + 8'(n), 1'b1, 1'b0);
      checks++;
      if (cnt_c !== 2'd3 || fidx_c !== 2'd2 || fail_c !== 1'b1) begin
         errors++;
         $display("FAIL saturate: cnt=%0d idx=%0d fail=%b expected 3/2/1", cnt_c, fidx_c, fail_c);
      end
      checks++;
      if (cnt_a !== 8'd4) begin errors++; $display("FAIL count_wide: got %0d expected 4", cnt_a); end
      cycle(8'h82, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset_and_clear();
      do_reset();
      cycle(8'h80, 8'h64, 1'b1, 1'b0);
      cycle(8'h81, 8'h07, 1'b1, 1'b0);
      cycle(8'h80, 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      checks++;
      if (dout_a !== 8'h00 || ok_a !== 1'b0) begin
         errors++; $display("FAIL async_reset: dout=%h ok=%b expected 00/0", dout_a, ok_a);
      end
      do_reset();
      cycle(8'h81, 8'h00, 1'b0, 1'b0);
      cycle(8'h80, 8'h64, 1'b1, 1'b0);
      cycle(8'h81, 8'h07, 1'b1, 1'b0);
      cycle(8'h82, 8'h00, 1'b1, 1'b0);
      cycle(8'h81, 8'h99, 1'b1, 1'b0);
      cycle(8'h80, 8'h55, 1'b1, 1'b1);
      checks++;
      if ({ok_a, fail_a, cnt_a, fidx_a} !== 11'h0) begin
         errors++;
         $display("FAIL clear_state: ok=%b fail=%b cnt=%0d idx=%0d expected all 0", ok_a, fail_a, cnt_a, fidx_a);
      end
      cycle(8'h80, 8'h00, 1'b0, 1'b0);
      cycle(8'h81, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; addr = 8'h00; data_in = 8'h00; write_en = 1'b0;
      test_reset();
      test_correct_image();
      test_mismatch_correction();
      test_out_of_window();
      test_readback();
      test_saturation();
      test_async_reset_and_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
